// File: rtl/mul_pkg.sv
// Shared types and widths for the sequential 16x16 multiplier built on the 8x8 core.
package mul_pkg;

  localparam int HALF_W      = 8;
  localparam int FULL_W      = 16;
  localparam int PROD_W      = 32;
  localparam int MUL16_BEATS = 4;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  // Two's-complement magnitude; 0x8000 maps to 0x8000, which is correct as an unsigned value.
  function automatic logic [FULL_W-1:0] mag16(input logic [FULL_W-1:0] v);
    return v[FULL_W-1] ? (~v + FULL_W'(1)) : v;
  endfunction

endpackage

// File: rtl/mul16_seq_wtm8.sv
// WTM8: the shared 8x8 -> 16-bit unsigned combinational multiplier core.
module WTM8
  import mul_pkg::*;
(
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  output logic [FULL_W-1:0] p
);

  assign p = {{HALF_W{1'b0}}, a} * {{HALF_W{1'b0}}, b};

endmodule

// File: rtl/mul16_seq.sv
// Sequential 16x16 -> 32 unsigned multiplier: four 8x8 beats through one WTM8 core.
// Optional signed mode (op_signed input) enabled by macro MUL16_SEQ_SIGNED_EN.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// MUL   | beats 0..3 accumulate partial products
// DONE  | result presented; retires on out_ready, may accept next request same edge
module mul16_seq
  import mul_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FULL_W-1:0] in_a,
  input  logic [FULL_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
`ifdef MUL16_SEQ_SIGNED_EN
  input  logic              op_signed,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_p,
  output logic [TAG_W-1:0]  out_tag
);

  state_t              state_q, state_d;
  logic [1:0]          beat_q;
  logic [FULL_W-1:0]   a_q, b_q;
  logic [TAG_W-1:0]    tag_q;
  logic [PROD_W-1:0]   acc_q;
  logic                neg_q;

  logic [FULL_W-1:0]   a_in, b_in;
  logic                neg_in;
  logic [HALF_W-1:0]   core_a, core_b;
  logic [FULL_W-1:0]   core_p;
  logic [PROD_W-1:0]   addend, sum;
  logic                accept, last_beat;

`ifdef MUL16_SEQ_SIGNED_EN
  always_comb begin
    a_in   = op_signed ? mag16(in_a) : in_a;
    b_in   = op_signed ? mag16(in_b) : in_b;
    neg_in = op_signed & (in_a[FULL_W-1] ^ in_b[FULL_W-1]);
  end
`else
  always_comb begin
    a_in   = in_a;
    b_in   = in_b;
    neg_in = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = MUL;
      end
      MUL: begin
        if (last_beat) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_d = in_valid ? MUL : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign last_beat = (beat_q == 2'(MUL16_BEATS - 1));

  // beat[1] picks the a half, beat[0] picks the b half
  assign core_a = beat_q[1] ? a_q[FULL_W-1:HALF_W] : a_q[HALF_W-1:0];
  assign core_b = beat_q[0] ? b_q[FULL_W-1:HALF_W] : b_q[HALF_W-1:0];

  WTM8 u_core (
    .a (core_a),
    .b (core_b),
    .p (core_p)
  );

  always_comb begin
    addend = '0;
    unique case (beat_q)
      2'd0:       addend = {{FULL_W{1'b0}}, core_p};
      2'd1, 2'd2: addend = {{HALF_W{1'b0}}, core_p, {HALF_W{1'b0}}};
      default:    addend = {core_p, {FULL_W{1'b0}}};
    endcase
  end

  assign sum = acc_q + addend;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= '0;
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      tag_q  <= '0;
      neg_q  <= 1'b0;
    end else if (accept) begin
      beat_q <= '0;
      acc_q  <= '0;
      a_q    <= a_in;
      b_q    <= b_in;
      tag_q  <= in_tag;
      neg_q  <= neg_in;
    end else if (state_q == MUL) begin
      beat_q <= beat_q + 2'd1;
      // sign fix-up is folded into the final beat so DONE sees the finished value
      if (last_beat && neg_q) acc_q <= -sum;
      else                    acc_q <= sum;
    end
  end

  assign out_p   = acc_q;
  assign out_tag = tag_q;

endmodule

// File: tb/tb_mul16_seq.sv
// Self-checking bench for mul16_seq: vector table, handshake corner cases, random scoreboard.
module tb_mul16_seq;

`ifdef MUL16_SEQ_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif
  localparam int N_RAND = 3000;
  localparam int RAND_BUDGET = 60000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic        op_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_p;
  logic [3:0]  out_tag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul16_seq #(.TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
`ifdef MUL16_SEQ_SIGNED_EN
    .op_signed (op_signed),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_tag   (out_tag)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  tag;
    logic [31:0] p;
  } vec_t;

  typedef struct {
    logic [31:0] p;
    logic [3:0]  tag;
  } res_t;

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input logic sgn);
    longint pa, pb;
    pa = sgn ? longint'($signed(a)) : longint'(a);
    pb = sgn ? longint'($signed(b)) : longint'(b);
    return 32'(pa * pb);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag,
                        input logic sgn, input logic rdy,
                        output logic [31:0] p, output logic [3:0] t, output int lat);
    int guard;
    in_a = a; in_b = b; in_tag = tag; op_signed = sgn;
    in_valid = 1'b1; out_ready = rdy;
    #1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    chk("accept_wait", 32'(guard < 20), 32'd1);
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    p = out_p;
    t = out_tag;
  endtask

  vec_t vecs[8];

  initial begin
    logic [31:0] p;
    logic [3:0]  t;
    int          lat;
    int          cnt;

    vecs[0] = '{16'h1234, 16'h5678, 4'd3,  32'h0626_0060};
    vecs[1] = '{16'h0000, 16'h0000, 4'd0,  32'h0000_0000};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 4'd15, 32'hFFFE_0001};
    vecs[3] = '{16'hFFFF, 16'h0001, 4'd1,  32'h0000_FFFF};
    vecs[4] = '{16'h0100, 16'h0100, 4'd2,  32'h0001_0000};
    vecs[5] = '{16'h0002, 16'h0003, 4'd9,  32'h0000_0006};
    vecs[6] = '{16'h00FF, 16'hFF00, 4'd4,  32'h00FE_0100};
    vecs[7] = '{16'h8000, 16'h8000, 4'd6,  32'h4000_0000};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
    op_signed = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_p",     out_p,          32'd0);
    chk("rst_out_tag",   32'(out_tag),   32'd0);

    // table of unsigned vectors, each with latency check
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].tag, 1'b0, 1'b1, p, t, lat);
      chk($sformatf("tbl%0d_p", i),   p,         vecs[i].p);
      chk($sformatf("tbl%0d_tag", i), 32'(t),    32'(vecs[i].tag));
      chk($sformatf("tbl%0d_lat", i), 32'(lat),  32'd4);
      step();
      chk($sformatf("tbl%0d_retire", i), 32'(out_valid), 32'd0);
    end

    // back-pressure: result held while out_ready low, new request blocked
    run_op(16'hFFFF, 16'hFFFF, 4'd5, 1'b0, 1'b0, p, t, lat);
    chk("bp_p", p, 32'hFFFE_0001);
    chk("bp_tag", 32'(t), 32'd5);
    in_valid = 1'b1; in_a = 16'h0003; in_b = 16'h0003; in_tag = 4'd8;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_p",     out_p,          32'hFFFE_0001);
      chk("bp_hold_tag",   32'(out_tag),   32'd5);
      chk("bp_in_ready",   32'(in_ready),  32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("bp_release", 32'(out_valid), 32'd0);
    chk("bp_idle_ready", 32'(in_ready), 32'd1);

    // back-to-back: in_valid held high, retire and accept on the same edge
    begin
      logic [15:0] ba[3];
      logic [15:0] bb[3];
      int          out_cyc[3];
      int          idx, k;
      logic        hs;
      ba = '{16'h0003, 16'h1234, 16'hFFFF};
      bb = '{16'h0004, 16'h5678, 16'h0002};
      idx = 0; k = 0;
      in_a = ba[0]; in_b = bb[0]; in_tag = 4'd1; op_signed = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      for (int cyc = 0; cyc < 30; cyc++) begin
        if (out_valid) begin
          if (k < 3) begin
            chk($sformatf("b2b%0d_p", k),   out_p,        ref_mul(ba[k], bb[k], 1'b0));
            chk($sformatf("b2b%0d_tag", k), 32'(out_tag), 32'(k + 1));
            out_cyc[k] = cyc;
          end
          k++;
        end
        hs = in_valid & in_ready;
        step();
        if (hs) begin
          idx++;
          if (idx < 3) begin
            in_a = ba[idx]; in_b = bb[idx]; in_tag = 4'(idx + 1);
          end else begin
            in_valid = 1'b0;
          end
        end
      end
      chk("b2b_count", 32'(k), 32'd3);
      if (k >= 3) begin
        chk("b2b_gap01", 32'(out_cyc[1] - out_cyc[0]), 32'd5);
        chk("b2b_gap12", 32'(out_cyc[2] - out_cyc[1]), 32'd5);
      end
    end

    // reset during beat 2 discards the operation
    in_a = 16'h1234; in_b = 16'h5678; in_tag = 4'd11; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    chk("midrst_out_p",     out_p,          32'd0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid) cnt++;
    end
    chk("midrst_no_result", 32'(cnt), 32'd0);
    run_op(16'd2, 16'd3, 4'd7, 1'b0, 1'b1, p, t, lat);
    chk("midrst_next_p", p, 32'd6);
    chk("midrst_next_tag", 32'(t), 32'd7);
    chk("midrst_next_lat", 32'(lat), 32'd4);
    step();

`ifdef MUL16_SEQ_SIGNED_EN
    run_op(16'hFFFF, 16'h0001, 4'd1, 1'b1, 1'b1, p, t, lat);
    chk("s_m1x1", p, 32'hFFFF_FFFF);
    chk("s_m1x1_lat", 32'(lat), 32'd4);
    step();
    run_op(16'h8000, 16'h8000, 4'd2, 1'b1, 1'b1, p, t, lat);
    chk("s_min_sq", p, 32'h4000_0000);
    step();
    run_op(16'hFFFD, 16'h0005, 4'd3, 1'b1, 1'b1, p, t, lat);
    chk("s_m3x5", p, 32'hFFFF_FFF1);
    step();
    run_op(16'hFFFF, 16'h0001, 4'd4, 1'b0, 1'b1, p, t, lat);
    chk("s_unsigned_mode", p, 32'h0000_FFFF);
    step();
`endif

    // random traffic with stalls, checked against the arithmetic reference
    begin
      res_t        exp_q[$];
      res_t        r;
      int          n_sent, n_recv, cyc;
      logic        hs_in, hs_out, held;
      logic [31:0] held_p;
      logic [3:0]  held_t;
      n_sent = 0; n_recv = 0; cyc = 0; held = 1'b0; held_p = '0; held_t = '0;

      out_ready = ($urandom_range(0, 3) != 0);
      in_valid = 1'b0;
      while (n_recv < N_RAND && cyc < RAND_BUDGET) begin
        if (!in_valid && n_sent < N_RAND && $urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          case ($urandom_range(0, 7))
            0: in_a = 16'h0000;
            1: in_a = 16'hFFFF;
            2: in_a = 16'h8000;
            default: in_a = 16'($urandom);
          endcase
          case ($urandom_range(0, 7))
            0: in_b = 16'h0000;
            1: in_b = 16'hFFFF;
            2: in_b = 16'h8000;
            default: in_b = 16'($urandom);
          endcase
          in_tag = 4'($urandom);
          op_signed = SIGNED_BUILD ? 1'($urandom) : 1'b0;
        end
        @(negedge clk);
        hs_in  = in_valid & in_ready;
        hs_out = out_valid & out_ready;
        if (held) begin
          chk("rnd_stall_valid", 32'(out_valid), 32'd1);
          chk("rnd_stall_p",     out_p,          held_p);
          chk("rnd_stall_tag",   32'(out_tag),   32'(held_t));
        end
        if (hs_out) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rnd_spurious: got result 0x%08h with nothing outstanding", out_p);
          end else begin
            r = exp_q.pop_front();
            chk("rnd_p",   out_p,        r.p);
            chk("rnd_tag", 32'(out_tag), 32'(r.tag));
          end
          n_recv++;
        end
        held   = out_valid & ~out_ready;
        held_p = out_p;
        held_t = out_tag;
        if (hs_in) begin
          r.p   = ref_mul(in_a, in_b, op_signed);
          r.tag = in_tag;
          exp_q.push_back(r);
          n_sent++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (hs_in) in_valid = 1'b0;
        out_ready = ($urandom_range(0, 3) != 0);
      end
      in_valid = 1'b0;
      chk("rnd_received", 32'(n_recv), 32'(N_RAND));
      chk("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
